// File: rtl/elut_cfg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : elut_cfg_sequencer_if
// Description : Byte-serial configuration stream (valid/ready) feeding the
//               eLUT configuration sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface elut_cfg_sequencer_if #(
    parameter int WORD_WIDTH = 8
);
    logic [WORD_WIDTH-1:0] cfg_data;
    logic                  cfg_valid;
    logic                  cfg_ready;

    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready
    );
endinterface
`default_nettype wire

// File: rtl/elut_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : elut_cfg_sequencer
// Description : Packs a word stream into NUM_LUTS-bit frames and writes one
//               frame per address to a column of eLUTs, sweeping 0..2**K-1.
//               Optional trailing-XOR checksum: ELUT_CFG_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module elut_cfg_sequencer #(
    parameter int K          = 6,
    parameter int NUM_LUTS   = 16,
    parameter int WORD_WIDTH = 8
) (
    input  wire                   clk,
    input  wire                   rst,
    input  wire                   start,
    elut_cfg_sequencer_if.slave   cfg,
    output logic [K-1:0]          lut_addr,
    output logic [NUM_LUTS-1:0]   lut_wdata,
    output logic                  lut_we,
    output logic                  busy,
    output logic                  done
`ifdef ELUT_CFG_CHECKSUM_EN
    ,
    output logic                  err
`endif
);

    localparam int c_WPF = (NUM_LUTS + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int c_FW  = c_WPF * WORD_WIDTH;
    localparam int c_WCW = (c_WPF > 1) ? $clog2(c_WPF) : 1;
    localparam logic [c_WCW-1:0] c_LAST_WORD = c_WCW'(c_WPF - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_WRITE = 3'd2;
`ifdef ELUT_CFG_CHECKSUM_EN
    localparam logic [2:0] c_CHECK = 3'd3;
`endif
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]          r_state;
    logic [c_WCW-1:0]    r_word_cnt;
    logic [c_FW-1:0]     r_frame;
    logic [K-1:0]        r_addr;
    logic [NUM_LUTS-1:0] r_wdata;
    logic                r_ready;
    logic                r_we;
    logic                r_busy;
    logic                r_done;
`ifdef ELUT_CFG_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] r_csum;
    logic                  r_err;
`endif

    logic [c_FW-1:0] w_frame_next;
    logic            w_accept;

    assign w_accept = r_ready & cfg.cfg_valid;

    // Frame is kept word-aligned; bits at or above NUM_LUTS never leave it.
    always_comb begin
        w_frame_next = r_frame;
        for (int j = 0; j < c_WPF; j++) begin
            if (r_word_cnt == c_WCW'(j)) begin
                w_frame_next[j*WORD_WIDTH +: WORD_WIDTH] = cfg.cfg_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_word_cnt <= '0;
            r_frame    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ready    <= 1'b0;
            r_we       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef ELUT_CFG_CHECKSUM_EN
            r_csum     <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state    <= c_LOAD;
                        r_word_cnt <= '0;
                        r_frame    <= '0;
                        r_addr     <= '0;
                        r_ready    <= 1'b1;
                        r_busy     <= 1'b1;
`ifdef ELUT_CFG_CHECKSUM_EN
                        r_csum     <= '0;
                        r_err      <= 1'b0;
`endif
                    end
                end

                c_LOAD: begin
                    if (w_accept) begin
                        r_frame <= w_frame_next;
`ifdef ELUT_CFG_CHECKSUM_EN
                        r_csum  <= r_csum ^ cfg.cfg_data;
`endif
                        if (r_word_cnt == c_LAST_WORD) begin
                            r_state <= c_WRITE;
                            r_ready <= 1'b0;
                            r_we    <= 1'b1;
                            r_wdata <= w_frame_next[NUM_LUTS-1:0];
                        end else begin
                            r_word_cnt <= r_word_cnt + 1'b1;
                        end
                    end
                end

                c_WRITE: begin
                    r_we <= 1'b0;
                    if (&r_addr) begin
`ifdef ELUT_CFG_CHECKSUM_EN
                        r_state <= c_CHECK;
                        r_ready <= 1'b1;
`else
                        r_state <= c_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_state    <= c_LOAD;
                        r_addr     <= r_addr + 1'b1;
                        r_word_cnt <= '0;
                        r_frame    <= '0;
                        r_ready    <= 1'b1;
                    end
                end

`ifdef ELUT_CFG_CHECKSUM_EN
                c_CHECK: begin
                    if (w_accept) begin
                        r_err   <= (cfg.cfg_data != r_csum);
                        r_state <= c_DONE;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
`endif

                c_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                    r_ready <= 1'b0;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg.cfg_ready = r_ready;
    assign lut_addr      = r_addr;
    assign lut_wdata     = r_wdata;
    assign lut_we        = r_we;
    assign busy          = r_busy;
    assign done          = r_done;
`ifdef ELUT_CFG_CHECKSUM_EN
    assign err           = r_err;
`endif

endmodule
`default_nettype wire
